// File: rtl/wb_arbiter_scoreboard.sv
// Round-robin write-back arbiter onto the single regfile write port,
// plus a 32-entry busy scoreboard that stalls decode on RAW/WAW hazards.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   issueValid/RdWen/Rd/Rs1/Rs2   decode-side instruction
//   issueStall                    hazard stall (comb)
//   flush                         clear all busy bits
//   reqValid/reqRd/reqData        per-requester write-back
//   reqReady                      one-hot grant (comb)
//   rdWriteEn/rd/rdData           registered regfile write port
//   pendingCnt                    popcount of busy bits (comb)
module wb_arbiter_scoreboard #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issueValid,
  input  logic              issueRdWen,
  input  logic [4:0]        issueRd,
  input  logic [4:0]        issueRs1,
  input  logic [4:0]        issueRs2,
  output logic              issueStall,
  input  logic              flush,
  input  logic [NREQ-1:0]   reqValid,
  input  logic [5*NREQ-1:0] reqRd,
  input  logic [32*NREQ-1:0] reqData,
  output logic [NREQ-1:0]   reqReady,
  output logic              rdWriteEn,
  output logic [4:0]        rd,
  output logic [31:0]       rdData,
  output logic [5:0]        pendingCnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rrPtr;
  logic [31:0]   busy;
  logic [31:0]   busyNxt;
  logic [PW-1:0] gIdx;
  logic          gAny;
  logic [4:0]    selRd;
  logic [31:0]   selData;
  logic          setEn;
  int            idx;

  // Search starts one past the last winner.
  always_comb begin
    reqReady = '0;
    gIdx     = '0;
    gAny     = 1'b0;
    selRd    = '0;
    selData  = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rrPtr) + k) % NREQ;
      if (!gAny && reqValid[idx]) begin
        gAny    = 1'b1;
        gIdx    = PW'(idx);
        selRd   = reqRd[5*idx +: 5];
        selData = reqData[32*idx +: 32];
      end
    end
    if (gAny) reqReady[gIdx] = 1'b1;
  end

  // A grant always coincides with valid, so gAny is the transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdWriteEn <= 1'b0;
      rd        <= '0;
      rdData    <= '0;
      rrPtr     <= PW'(NREQ - 1);
    end else begin
      rdWriteEn <= gAny && (selRd != 5'd0);
      if (gAny) begin
        rrPtr <= gIdx;
        if (selRd != 5'd0) begin
          rd     <= selRd;
          rdData <= selData;
        end
      end
    end
  end

  // No bypass: the register being written this cycle is still busy.
  assign issueStall = issueValid & (
      ((issueRs1 != 5'd0) & busy[issueRs1]) |
      ((issueRs2 != 5'd0) & busy[issueRs2]) |
      (issueRdWen & (issueRd != 5'd0) & busy[issueRd]));

  assign setEn = issueValid & issueRdWen & (issueRd != 5'd0) &
                 ~issueStall & ~flush;

  // Set is applied after clear so it wins on a same-register collision.
  always_comb begin
    busyNxt = busy;
    if (rdWriteEn) busyNxt[rd] = 1'b0;
    if (setEn) busyNxt[issueRd] = 1'b1;
    if (flush) busyNxt = '0;
    busyNxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= busyNxt;
  end

  always_comb begin
    pendingCnt = '0;
    for (int i = 0; i < 32; i++)
      pendingCnt = pendingCnt + 6'(busy[i]);
  end

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Scoreboard bench for wb_arbiter_scoreboard: stimulus pushes expected
// grants/writes, negedge monitors pop and compare.
module tb_wb_arbiter_scoreboard;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              issueValid, issueRdWen;
  logic [4:0]        issueRd, issueRs1, issueRs2;
  logic              issueStall;
  logic              flush;
  logic [NREQ-1:0]   reqValid;
  logic [5*NREQ-1:0] reqRd;
  logic [32*NREQ-1:0] reqData;
  logic [NREQ-1:0]   reqReady;
  logic              rdWriteEn;
  logic [4:0]        rd;
  logic [31:0]       rdData;
  logic [5:0]        pendingCnt;

  int checks = 0;
  int failures = 0;
  int gq[$];
  logic [36:0] wq[$];
  logic prevNz = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_scoreboard #(.NREQ(NREQ)) dut (
    .clk(clk), .rstn(rstn),
    .issueValid(issueValid), .issueRdWen(issueRdWen),
    .issueRd(issueRd), .issueRs1(issueRs1), .issueRs2(issueRs2),
    .issueStall(issueStall), .flush(flush),
    .reqValid(reqValid), .reqRd(reqRd), .reqData(reqData),
    .reqReady(reqReady), .rdWriteEn(rdWriteEn), .rd(rd),
    .rdData(rdData), .pendingCnt(pendingCnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_issue();
    issueValid = 0; issueRdWen = 0;
    issueRd = 0; issueRs1 = 0; issueRs2 = 0;
    flush = 0;
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (rstn) begin
      chk("ready_subset", 64'(reqReady & ~reqValid), 64'd0);
      if ((reqValid & reqReady) != '0) begin
        int g;
        g = 0;
        for (int i = NREQ - 1; i >= 0; i--)
          if (reqReady[i]) g = i;
        chk("ready_onehot", 64'($onehot(reqReady)), 64'd1);
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL grant_unexpected actual=%0d expected=none", g);
        end else begin
          chk("grant_idx", 64'(g), 64'(gq.pop_front()));
        end
      end
    end
  end

  // Write monitor
  always @(negedge clk) begin
    if (!rstn) begin
      prevNz = 1'b0;
    end else begin
      logic [4:0] srd;
      chk("wen_latency", 64'(rdWriteEn), 64'(prevNz));
      if (rdWriteEn) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL write_unexpected actual=rd%0d expected=none", rd);
        end else begin
          logic [36:0] e;
          e = wq.pop_front();
          chk("write_rd", 64'(rd), 64'(e[36:32]));
          chk("write_data", 64'(rdData), 64'(e[31:0]));
        end
      end
      srd = '0;
      for (int i = 0; i < NREQ; i++)
        if (reqReady[i] && reqValid[i]) srd = reqRd[5*i +: 5];
      prevNz = ((reqValid & reqReady) != '0) && (srd != 5'd0);
    end
  end

  initial begin
    rstn = 0;
    clr_issue();
    reqValid = '0; reqRd = '0; reqData = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", 64'(rdWriteEn), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_data", 64'(rdData), 64'd0);
    chk("rst_pcnt", 64'(pendingCnt), 64'd0);
    chk("rst_ready", 64'(reqReady), 64'd0);
    tick();
    rstn = 1;
    tick();

    // Round robin over three held requesters
    reqRd[4:0] = 5'd1; reqRd[9:5] = 5'd2; reqRd[14:10] = 5'd3;
    reqData[31:0] = 32'hA000_0001;
    reqData[63:32] = 32'hB000_0002;
    reqData[95:64] = 32'hC000_0003;
    reqValid = 3'b111;
    for (int r = 0; r < 2; r++) begin
      gq.push_back(0); gq.push_back(1); gq.push_back(2);
      wq.push_back({5'd1, 32'hA000_0001});
      wq.push_back({5'd2, 32'hB000_0002});
      wq.push_back({5'd3, 32'hC000_0003});
    end
    repeat (6) tick();
    reqValid = '0;
    repeat (2) tick();

    // RAW stall until the write has landed
    issueValid = 1; issueRdWen = 1; issueRd = 5'd5;
    @(negedge clk);
    chk("t3_issue_nostall", 64'(issueStall), 64'd0);
    tick();
    clr_issue();
    issueValid = 1; issueRs1 = 5'd5;
    reqRd[9:5] = 5'd5; reqData[63:32] = 32'h5555_0005;
    reqValid = 3'b010;
    gq.push_back(1);
    wq.push_back({5'd5, 32'h5555_0005});
    @(negedge clk);
    chk("t3_stall", 64'(issueStall), 64'd1);
    chk("t3_pcnt1", 64'(pendingCnt), 64'd1);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("t3_wen", 64'(rdWriteEn), 64'd1);
    chk("t3_stall_nobypass", 64'(issueStall), 64'd1);
    tick();
    @(negedge clk);
    chk("t3_unstall", 64'(issueStall), 64'd0);
    chk("t3_pcnt0", 64'(pendingCnt), 64'd0);
    tick();
    clr_issue();

    // x0 never busy; rd=0 write-back accepted silently
    issueValid = 1; issueRdWen = 1;
    reqRd[4:0] = 5'd0; reqData[31:0] = 32'hDEAD_0000;
    reqValid = 3'b001;
    gq.push_back(0);
    @(negedge clk);
    chk("t4_nostall", 64'(issueStall), 64'd0);
    tick();
    reqValid = '0;
    @(negedge clk);
    chk("t4_pcnt", 64'(pendingCnt), 64'd0);
    chk("t4_wen0", 64'(rdWriteEn), 64'd0);
    tick();
    clr_issue();

    // Flush overrides a same-cycle set
    issueValid = 1; issueRdWen = 1; issueRd = 5'd3;
    tick();
    issueRd = 5'd7;
    tick();
    clr_issue();
    @(negedge clk);
    chk("t5_pcnt2", 64'(pendingCnt), 64'd2);
    tick();
    issueValid = 1; issueRdWen = 1; issueRd = 5'd9; flush = 1;
    @(negedge clk);
    chk("t5_nostall", 64'(issueStall), 64'd0);
    tick();
    clr_issue();
    issueValid = 1; issueRs1 = 5'd9; issueRs2 = 5'd3;
    @(negedge clk);
    chk("t5_pcnt0", 64'(pendingCnt), 64'd0);
    chk("t5_busy_clear", 64'(issueStall), 64'd0);
    tick();
    clr_issue();

    // Reset right after a transfer drops the write
    reqRd[14:10] = 5'd4; reqData[95:64] = 32'h4444_0004;
    reqValid = 3'b100;
    gq.push_back(2);
    tick();
    rstn = 0;
    reqValid = '0;
    @(negedge clk);
    chk("t6_wen", 64'(rdWriteEn), 64'd0);
    chk("t6_rd", 64'(rd), 64'd0);
    chk("t6_data", 64'(rdData), 64'd0);
    chk("t6_ready", 64'(reqReady), 64'd0);
    tick();
    rstn = 1;
    repeat (2) tick();

    // Pointer back at reset value: req0 first
    reqRd[4:0] = 5'd1; reqData[31:0] = 32'hA000_0001;
    reqValid = 3'b111;
    gq.push_back(0);
    wq.push_back({5'd1, 32'hA000_0001});
    tick();
    reqValid = '0;
    repeat (3) tick();

    chk("grant_q_empty", 64'(gq.size()), 64'd0);
    chk("write_q_empty", 64'(wq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
